// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB requester. Commands arrive on a valid/ready stream.
// Each one becomes an APB SETUP/ACCESS transfer, and its completion is
// returned on a valid/ready response channel. A programmable wait-state
// timeout aborts the transfer when the slave holds pready low too long.
//
// Parameters
//   ADDR_W   width of i_cmd_addr / o_paddr
//   DATA_W   width of write / read data
//   TIMEOUT  max consecutive pready-low ACCESS cycles before abort (0 = off)
//
// Ports
//   i_clk, i_reset        rising-edge clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_write, i_cmd_addr, i_cmd_wdata
//                         command stream (accepted on valid && ready)
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err, o_rsp_timeout
//                         response stream (consumed on valid && ready)
//   o_psel, o_penable, o_paddr, o_pwrite, o_pwdata
//                         APB request outputs
//   i_prdata, i_pready, i_pslverr
//                         APB slave returns
//
// Every output is a register except o_cmd_ready, which is decoded from the
// state register only, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,

    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout,

    output logic              o_psel,
    output logic              o_penable,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    // Wait counter must be able to hold TIMEOUT itself; at least one bit.
    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout_hit;

    // Saturating increment: the counter never wraps back to a small value,
    // so a slave that stalls indefinitely cannot dodge the timeout.
    assign w_cnt_next = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    // w_cnt_next counts the current low-pready cycle, so hitting the limit
    // here means this is the TIMEOUT-th consecutive stalled ACCESS cycle.
    // The state leaves ACCESS on that edge, so equality is always reached.
    assign w_timeout_hit = TO_EN && (w_cnt_next == TO_LIMIT);

    assign o_cmd_ready = (r_state == StIdle);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_wait_cnt    <= '0;
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_paddr       <= '0;
            o_pwrite      <= 1'b0;
            o_pwdata      <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        // Request fields are captured once and then held
                        // until the next accepted command.
                        o_paddr   <= i_cmd_addr;
                        o_pwrite  <= i_cmd_write;
                        o_pwdata  <= i_cmd_wdata;
                        o_psel    <= 1'b1;
                        o_penable <= 1'b0;
                        r_state   <= StSetup;
                    end
                end

                StSetup: begin
                    o_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= StAccess;
                end

                StAccess: begin
                    if (i_pready) begin
                        // A ready slave wins over a coincident timeout.
                        o_psel        <= 1'b0;
                        o_penable     <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= o_pwrite ? '0 : i_prdata;
                        o_rsp_err     <= i_pslverr;
                        o_rsp_timeout <= 1'b0;
                        r_state       <= StResp;
                    end else begin
                        r_wait_cnt <= w_cnt_next;
                        if (w_timeout_hit) begin
                            o_psel        <= 1'b0;
                            o_penable     <= 1'b0;
                            o_rsp_valid   <= 1'b1;
                            o_rsp_rdata   <= '0;
                            o_rsp_err     <= 1'b1;
                            o_rsp_timeout <= 1'b1;
                            r_state       <= StResp;
                        end
                    end
                end

                StResp: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
